// File: rtl/vm2_vic_if.sv
// Interrupt-side bus between peripheral controllers, the 1801VM2 core and the VIC.
// The slave modport is the controller; the master modport is the devices plus processor.
interface vm2_vic_if #(
    parameter int N = 8
);
    logic [N-1:0]    irq_i;
    logic [16*N-1:0] ivec_i;
    logic [N-1:0]    dev_ack_o;
    logic            virq_o;
    logic            istb_i;
    logic            iack_o;
    logic [15:0]     ivec_o;

    modport slave (
        input  irq_i, ivec_i, istb_i,
        output dev_ack_o, virq_o, iack_o, ivec_o
    );

    modport master (
        output irq_i, ivec_i, istb_i,
        input  dev_ack_o, virq_o, iack_o, ivec_o
    );
endinterface

// File: rtl/vm2_vic.sv
// Fixed-priority vectored interrupt controller for the 1801VM2 interrupt port.
// Line 0 wins; the vector read is answered Wishbone-classic style with a one-cycle device ack.
module vm2_vic #(
    parameter int          N        = 8,
    parameter logic [15:0] SPUR_VEC = 16'o000000
) (
    input logic        wb_clk_i,
    input logic        wb_rst_i,
    vm2_vic_if.slave   bus
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, GAP} state_t;

    state_t          state;
    logic [SELW-1:0] sel;
    logic [SELW-1:0] win;
    logic            any;
    logic            found;
    logic            virq;
    logic            iack;
    logic [15:0]     ivec;
    logic [N-1:0]    dev_ack;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.irq_i[i] && !found) begin
                win   = SELW'(i);
                found = 1'b1;
            end
        end
        any = |bus.irq_i;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            sel     <= '0;
            virq    <= 1'b0;
            iack    <= 1'b0;
            ivec    <= '0;
            dev_ack <= '0;
        end else begin
            case (state)
                IDLE: begin
                    virq <= 1'b0;
                    if (any) begin
                        sel   <= win;
                        virq  <= 1'b1;
                        state <= REQ;
                    end else if (bus.istb_i) begin
                        ivec  <= SPUR_VEC;
                        iack  <= 1'b1;
                        state <= HOLD;
                    end
                end
                REQ: begin
                    // The strobe freezes sel even if the request vanished this same cycle.
                    if (bus.istb_i) begin
                        ivec         <= bus.ivec_i[16*sel +: 16];
                        iack         <= 1'b1;
                        dev_ack[sel] <= 1'b1;
                        virq         <= 1'b0;
                        state        <= HOLD;
                    end else if (any) begin
                        sel <= win;
                    end else begin
                        virq  <= 1'b0;
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    dev_ack <= '0;
                    if (!bus.istb_i) begin
                        iack  <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    virq  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.virq_o    = virq;
    assign bus.iack_o    = iack;
    assign bus.ivec_o    = ivec;
    assign bus.dev_ack_o = dev_ack;
endmodule

// File: tb/tb_vm2_vic.sv
// Directed bench for vm2_vic: single request, pre-emption, withdrawal, full sweep, reset mid-cycle.
module tb_vm2_vic;
    localparam int N = 8;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

    vm2_vic_if #(.N(N)) bus ();

    vm2_vic #(.N(N), .SPUR_VEC(16'o000000)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int line, input logic [15:0] v);
        bus.ivec_i[16*line +: 16] = v;
    endtask

    initial begin
        bus.irq_i  = '0;
        bus.ivec_i = '0;
        bus.istb_i = 1'b0;

        // Reset state
        #1;
        check("rst_virq", 16'(bus.virq_o), 16'd0);
        check("rst_iack", 16'(bus.iack_o), 16'd0);
        check("rst_ivec", bus.ivec_o, 16'd0);
        check("rst_ack", 16'(bus.dev_ack_o), 16'd0);
        tick();
        wb_rst_i = 1'b0;
        tick();
        check("idle_virq", 16'(bus.virq_o), 16'd0);

        // Single request on line 3
        set_vec(3, 16'o000060);
        bus.irq_i = 8'b0000_1000;
        tick();
        check("s_virq", 16'(bus.virq_o), 16'd1);
        bus.istb_i = 1'b1;
        tick();
        check("s_iack", 16'(bus.iack_o), 16'd1);
        check("s_ivec", bus.ivec_o, 16'o000060);
        check("s_ack", 16'(bus.dev_ack_o), 16'h0008);
        check("s_virq0", 16'(bus.virq_o), 16'd0);
        bus.irq_i = '0;
        tick();
        check("s_ack_w", 16'(bus.dev_ack_o), 16'h0000);
        check("s_iack2", 16'(bus.iack_o), 16'd1);
        tick();
        check("s_iack3", 16'(bus.iack_o), 16'd1);
        tick();
        check("s_iack4", 16'(bus.iack_o), 16'd1);
        check("s_ivec4", bus.ivec_o, 16'o000060);
        bus.istb_i = 1'b0;
        tick();
        check("s_iack_f", 16'(bus.iack_o), 16'd0);
        tick();
        check("s_gap", 16'(bus.virq_o), 16'd0);

        // Pre-emption: line 5 then line 1
        set_vec(5, 16'o000064);
        set_vec(1, 16'o000300);
        bus.irq_i = 8'b0010_0000;
        tick();
        check("p_virq", 16'(bus.virq_o), 16'd1);
        tick();
        bus.irq_i = 8'b0010_0010;
        tick();
        bus.istb_i = 1'b1;
        tick();
        check("p_ivec", bus.ivec_o, 16'o000300);
        check("p_ack", 16'(bus.dev_ack_o), 16'h0002);
        bus.irq_i  = 8'b0010_0000;
        bus.istb_i = 1'b0;
        tick();
        check("p_iack_f", 16'(bus.iack_o), 16'd0);
        check("p_virq_g", 16'(bus.virq_o), 16'd0);
        tick();
        check("p_virq_i", 16'(bus.virq_o), 16'd0);
        tick();
        check("p_virq_r", 16'(bus.virq_o), 16'd1);
        bus.istb_i = 1'b1;
        tick();
        check("p_ivec2", bus.ivec_o, 16'o000064);
        check("p_ack2", 16'(bus.dev_ack_o), 16'h0020);
        bus.irq_i  = '0;
        bus.istb_i = 1'b0;
        tick();
        tick();
        tick();

        // Withdrawal, then spurious vector read
        bus.irq_i = 8'b0000_0100;
        tick();
        check("w_virq", 16'(bus.virq_o), 16'd1);
        bus.irq_i = '0;
        tick();
        check("w_virq0", 16'(bus.virq_o), 16'd0);
        bus.istb_i = 1'b1;
        tick();
        check("w_iack", 16'(bus.iack_o), 16'd1);
        check("w_ivec", bus.ivec_o, 16'o000000);
        check("w_ack", 16'(bus.dev_ack_o), 16'h0000);
        bus.istb_i = 1'b0;
        tick();
        tick();

        // All lines at once, served 0..7
        for (int k = 0; k < N; k++) set_vec(k, 16'o000100 + 16'(4 * k));
        bus.irq_i = 8'hFF;
        for (int k = 0; k < N; k++) begin
            tick();
            check("a_virq", 16'(bus.virq_o), 16'd1);
            bus.istb_i = 1'b1;
            tick();
            check("a_ivec", bus.ivec_o, 16'o000100 + 16'(4 * k));
            check("a_ack", 16'(bus.dev_ack_o), 16'(1 << k));
            bus.irq_i[k] = 1'b0;
            tick();
            check("a_ack_w", 16'(bus.dev_ack_o), 16'h0000);
            bus.istb_i = 1'b0;
            tick();
            tick();
        end

        // Reset while holding the acknowledge
        set_vec(4, 16'o000070);
        bus.irq_i = 8'b0001_0000;
        tick();
        bus.istb_i = 1'b1;
        tick();
        check("r_iack1", 16'(bus.iack_o), 16'd1);
        check("r_ack1", 16'(bus.dev_ack_o), 16'h0010);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("r_iack", 16'(bus.iack_o), 16'd0);
        check("r_virq", 16'(bus.virq_o), 16'd0);
        check("r_ack", 16'(bus.dev_ack_o), 16'h0000);
        check("r_ivec", bus.ivec_o, 16'd0);
        bus.istb_i = 1'b0;
        bus.irq_i  = '0;
        tick();
        wb_rst_i = 1'b0;
        tick();
        check("r_idle", 16'(bus.virq_o), 16'd0);
        bus.irq_i = 8'b0100_0000;
        tick();
        check("r_virq_new", 16'(bus.virq_o), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
